// File: rtl/height_capture_ctrl.sv
// height_capture_ctrl: presence detector with hysteresis, hold-window timer,
// last/minimum capture, newest-first capture history and save indicator.
// Sits between the echo-to-inches converter and the display/history readers.
module height_capture_ctrl #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned DEPTH         = 10,
   parameter int unsigned ENTER_THRESH  = 10,
   parameter int unsigned EXIT_THRESH   = 12,
   parameter int unsigned HOLD_TICKS    = 36_000_000,
   parameter int unsigned LEAVE_SAMPLES = 4,
   parameter int unsigned FLASH_TICKS   = 3_000_000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sample_valid,
   input  logic [WIDTH-1:0]             inches_live,
   input  logic                         mode,
   input  logic                         clear_hist,
   input  logic [$clog2(DEPTH)-1:0]     rd_idx,
   output logic [WIDTH-1:0]             rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   hist_count,
   output logic [WIDTH-1:0]             display_value,
   output logic [1:0]                   state_out,
   output logic                         save_pulse,
   output logic                         abort_pulse,
   output logic                         led_save
);

   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam int unsigned LEAVE_W = $clog2(LEAVE_SAMPLES + 1);
   localparam int unsigned FLASH_W = (FLASH_TICKS > 0) ? $clog2(FLASH_TICKS + 1) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TIMING  = 2'd1,
      LATCHED = 2'd2
   } state_t;

   state_t               state;
   state_t               state_n;

   logic [WIDTH-1:0]     live_reg;
   logic [WIDTH-1:0]     live_n;
   logic [WIDTH-1:0]     cap;
   logic [WIDTH-1:0]     cap_n;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [HOLD_W-1:0]    hold_n;
   logic [LEAVE_W-1:0]   leave_cnt;
   logic [LEAVE_W-1:0]   leave_n;
   logic [FLASH_W-1:0]   flash_cnt;
   logic [FLASH_W-1:0]   flash_n;

   logic [WIDTH-1:0]     hist   [DEPTH];
   logic [WIDTH-1:0]     hist_n [DEPTH];
   logic [CNT_W-1:0]     count_n;
   logic [WIDTH-1:0]     rd_n;
   logic [WIDTH-1:0]     display_n;

   logic                 present_c;
   logic                 below_exit_c;
   logic                 absent_c;
   logic                 departed_c;
   logic                 hold_done_c;
   logic                 capture_c;
   logic                 abort_c;

   // Sample classification against the hysteresis thresholds
   always_comb begin
      present_c    = sample_valid && (32'(inches_live) < ENTER_THRESH);
      below_exit_c = sample_valid && (32'(inches_live) < EXIT_THRESH);
      absent_c     = sample_valid && !below_exit_c;
      departed_c   = absent_c && (leave_cnt == LEAVE_W'(LEAVE_SAMPLES - 1));
      hold_done_c  = (hold_cnt == HOLD_W'(HOLD_TICKS - 1));
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // FSM next state; departure beats the final hold cycle
   always_comb begin
      state_n   = state;
      capture_c = 1'b0;
      abort_c   = 1'b0;
      case (state)
         IDLE: begin
            if (present_c) begin
               state_n = TIMING;
            end
         end
         TIMING: begin
            if (departed_c) begin
               state_n = IDLE;
               abort_c = 1'b1;
            end else if (hold_done_c) begin
               state_n   = LATCHED;
               capture_c = 1'b1;
            end
         end
         LATCHED: begin
            if (departed_c) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Live value, departure counter, hold timer and capture value
   always_comb begin
      live_n  = live_reg;
      leave_n = leave_cnt;
      hold_n  = '0;
      cap_n   = cap;

      if (sample_valid) begin
         live_n = inches_live;
      end

      if (state_n != state) begin
         leave_n = '0;
      end else if (absent_c) begin
         if (leave_cnt != LEAVE_W'(LEAVE_SAMPLES)) begin
            leave_n = leave_cnt + LEAVE_W'(1);
         end
      end else if (sample_valid) begin
         leave_n = '0;
      end

      // The counter only runs while staying in TIMING, so it never wraps
      if ((state == TIMING) && (state_n == TIMING)) begin
         hold_n = hold_cnt + HOLD_W'(1);
      end

      case (state)
         IDLE: begin
            if (present_c) begin
               cap_n = inches_live;
            end
         end
         TIMING: begin
            if (below_exit_c) begin
               if (!mode || (inches_live < cap)) begin
                  cap_n = inches_live;
               end
            end
         end
         default: begin
            cap_n = cap;
         end
      endcase
   end

   // Save indicator countdown; a new capture reloads it
   always_comb begin
      flash_n = flash_cnt;
      if (capture_c) begin
         flash_n = FLASH_W'(FLASH_TICKS);
      end else if (flash_cnt != '0) begin
         flash_n = flash_cnt - FLASH_W'(1);
      end
   end

   // History update: clear is applied before a same-edge capture write
   always_comb begin
      hist_n  = hist;
      count_n = hist_count;
      if (clear_hist) begin
         hist_n  = '{default: '0};
         count_n = '0;
      end
      if (capture_c) begin
         for (int unsigned i = DEPTH - 1; i > 0; i--) begin
            hist_n[IDX_W'(i)] = hist_n[IDX_W'(i - 1)];
         end
         hist_n[0] = cap_n;
         if (count_n != CNT_W'(DEPTH)) begin
            count_n = count_n + CNT_W'(1);
         end
      end
   end

   // Read port and display selection
   always_comb begin
      rd_n = '0;
      if (CNT_W'(rd_idx) < hist_count) begin
         rd_n = hist[rd_idx];
      end
      display_n = (state_n == LATCHED) ? cap_n : live_n;
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live_reg      <= '0;
         cap           <= '0;
         hold_cnt      <= '0;
         leave_cnt     <= '0;
         flash_cnt     <= '0;
         hist          <= '{default: '0};
         hist_count    <= '0;
         rd_data       <= '0;
         display_value <= '0;
         save_pulse    <= 1'b0;
         abort_pulse   <= 1'b0;
         led_save      <= 1'b0;
      end else begin
         live_reg      <= live_n;
         cap           <= cap_n;
         hold_cnt      <= hold_n;
         leave_cnt     <= leave_n;
         flash_cnt     <= flash_n;
         hist          <= hist_n;
         hist_count    <= count_n;
         rd_data       <= rd_n;
         display_value <= display_n;
         save_pulse    <= capture_c;
         abort_pulse   <= abort_c;
         led_save      <= (flash_n != '0);
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_height_capture_ctrl.sv
// Directed bench for height_capture_ctrl with small hold/flash parameters.
module tb_height_capture_ctrl;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned HOLD  = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             sample_valid;
   logic [WIDTH-1:0] inches_live;
   logic             mode;
   logic             clear_hist;
   logic [1:0]       rd_idx;
   logic [WIDTH-1:0] rd_data;
   logic [2:0]       hist_count;
   logic [WIDTH-1:0] display_value;
   logic [1:0]       state_out;
   logic             save_pulse;
   logic             abort_pulse;
   logic             led_save;

   int errors = 0;
   int checks = 0;
   int led_hi;

   logic [7:0] pat   [4] = '{8'd9, 8'd5, 8'd8, 8'd6};
   logic [7:0] caps  [5] = '{8'd7, 8'd8, 8'd9, 8'd6, 8'd5};
   logic [7:0] reads [4] = '{8'd5, 8'd6, 8'd9, 8'd8};

   height_capture_ctrl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ENTER_THRESH(10), .EXIT_THRESH(12),
      .HOLD_TICKS(HOLD), .LEAVE_SAMPLES(2), .FLASH_TICKS(8)
   ) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid),
      .inches_live(inches_live), .mode(mode), .clear_hist(clear_hist),
      .rd_idx(rd_idx), .rd_data(rd_data), .hist_count(hist_count),
      .display_value(display_value), .state_out(state_out),
      .save_pulse(save_pulse), .abort_pulse(abort_pulse), .led_save(led_save)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v);
      sample_valid = 1'b1;
      inches_live  = v;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic capture_run(input logic [7:0] v);
      repeat (HOLD + 1) send(v);
   endtask

   initial begin
      reset = 1'b1; sample_valid = 1'b0; inches_live = '0; mode = 1'b0;
      clear_hist = 1'b0; rd_idx = '0;
      repeat (3) tick();
      check("rst_state", state_out, 0);
      check("rst_count", hist_count, 0);
      check("rst_rd", rd_data, 0);
      check("rst_disp", display_value, 0);
      check("rst_save", save_pulse, 0);
      check("rst_abort", abort_pulse, 0);
      check("rst_led", led_save, 0);
      reset = 1'b0;
      tick();

      // mode 0 steady 7s
      send(8'd7);
      check("t1_enter", state_out, 1);
      check("t1_disp_live", display_value, 7);
      repeat (HOLD - 1) send(8'd7);
      check("t1_pre_hold", state_out, 1);
      send(8'd7);
      check("t1_latched", state_out, 2);
      check("t1_save", save_pulse, 1);
      check("t1_led_on", led_save, 1);
      check("t1_disp", display_value, 7);
      check("t1_count", hist_count, 1);
      led_hi = 1;
      for (int i = 0; i < 10; i++) begin
         if (i < 2) send(8'd7); else tick();
         if (led_save) led_hi++;
         if (i == 0) check("t1_save_once", save_pulse, 0);
      end
      check("t1_led_len", led_hi, 8);
      check("t1_rd0", rd_data, 7);
      send(8'd30);
      check("t1_one_absent", state_out, 2);
      send(8'd30);
      check("t1_departed", state_out, 0);
      check("t1_disp_idle", display_value, 30);

      // mode 1 minimum
      mode = 1'b1;
      for (int k = 0; k <= int'(HOLD); k++) send(pat[k % 4]);
      check("t2_latched", state_out, 2);
      check("t2_save", save_pulse, 1);
      check("t2_disp_min", display_value, 5);
      repeat (3) send(8'd8);
      check("t2_disp_hold", display_value, 5);
      check("t2_still_lat", state_out, 2);
      send(8'd30);
      send(8'd30);
      check("t2_idle", state_out, 0);
      check("t2_count", hist_count, 2);
      rd_idx = 2'd1; tick();
      check("t2_rd1", rd_data, 7);
      rd_idx = 2'd0; tick();
      check("t2_rd0", rd_data, 5);

      // isolated absent sample then abort
      mode = 1'b0;
      send(8'd7); send(8'd30); send(8'd7); send(8'd30);
      check("t3_no_abort", state_out, 1);
      check("t3_no_abort_p", abort_pulse, 0);
      send(8'd30);
      check("t3_abort_state", state_out, 0);
      check("t3_abort", abort_pulse, 1);
      check("t3_nosave", save_pulse, 0);
      tick();
      check("t3_abort_once", abort_pulse, 0);
      check("t3_count", hist_count, 2);

      // threshold boundaries
      send(8'd10);
      check("b_idle10", state_out, 0);
      send(8'd11);
      check("b_idle11", state_out, 0);
      capture_run(8'd7);
      check("b_latched", state_out, 2);
      check("b_count", hist_count, 3);
      send(8'd12); send(8'd11);
      check("b_lat11", state_out, 2);
      send(8'd12);
      check("b_lat12", state_out, 2);
      send(8'd12);
      check("b_lat_exit", state_out, 0);

      // departure on the final hold edge
      repeat (HOLD - 1) send(8'd7);
      send(8'd30);
      check("b_late_timing", state_out, 1);
      send(8'd30);
      check("b_late_state", state_out, 0);
      check("b_late_abort", abort_pulse, 1);
      check("b_late_nosave", save_pulse, 0);
      check("b_late_count", hist_count, 3);

      // history fill and read
      clear_hist = 1'b1; tick(); clear_hist = 1'b0;
      check("h_clear", hist_count, 0);
      for (int c = 0; c < 5; c++) begin
         capture_run(caps[c]);
         send(8'd30); send(8'd30);
      end
      check("h_count_sat", hist_count, 4);
      for (int i = 0; i < 4; i++) begin
         rd_idx = 2'(i);
         tick();
         check($sformatf("h_rd%0d", i), rd_data, 32'(reads[i]));
      end
      repeat (HOLD) send(8'd4);
      clear_hist = 1'b1;
      send(8'd4);
      clear_hist = 1'b0;
      check("h_clr_cap_save", save_pulse, 1);
      check("h_clr_cap_count", hist_count, 1);
      rd_idx = 2'd0; tick();
      check("h_clr_rd0", rd_data, 4);
      rd_idx = 2'd1; tick();
      check("h_clr_rd1", rd_data, 0);
      send(8'd30); send(8'd30);

      // async reset mid-TIMING
      send(8'd7); send(8'd7); send(8'd7);
      check("r_timing", state_out, 1);
      reset = 1'b1;
      #2;
      check("r_async_state", state_out, 0);
      check("r_async_disp", display_value, 0);
      check("r_async_count", hist_count, 0);
      tick();
      reset = 1'b0;
      tick();
      check("r_nosave", save_pulse, 0);
      check("r_noabort", abort_pulse, 0);
      send(8'd7);
      check("r_restart", state_out, 1);
      repeat (HOLD - 1) send(8'd7);
      check("r_full_hold", state_out, 1);
      send(8'd7);
      check("r_capture", state_out, 2);
      check("r_save", save_pulse, 1);
      rd_idx = 2'd0;
      tick(); tick();
      check("r_led_mid", led_save, 1);
      check("r_rd_before", rd_data, 7);

      // async reset mid-flash
      reset = 1'b1;
      #2;
      check("r_flash_led", led_save, 0);
      check("r_flash_state", state_out, 0);
      check("r_flash_rd", rd_data, 0);
      check("r_flash_disp", display_value, 0);
      tick();
      reset = 1'b0;
      tick();
      check("r_flash_led_after", led_save, 0);
      check("r_flash_save", save_pulse, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
